disp_msg_scroller: RTL and testbench
====================================

DISP_MSG_SCROLLER -- requirements
Module: disp_msg_scroller

Interface
REQ-001 Parameter MSG_DEPTH, default 16, SHALL be the message buffer depth in 4-bit character codes (power of 2, 4..32).
REQ-002 Parameter TICK_DIV, default 12_500_000, SHALL be the clk cycles per scroll step (0.25 s at 50 MHz; minimum 2).
REQ-003 Parameter BLANK_CODE, default 4'hf, SHALL be the code driven on digits holding no character.
REQ-004 clk  input  1  system clock; reset and all logic are in the clk domain.
REQ-005 reset  input  1  reset, asynchronous, active-high.
REQ-006 wr_en  input  1  buffer write strobe.
REQ-007 wr_addr  input  $clog2(MSG_DEPTH)  buffer write index.
REQ-008 wr_data  input  4  character code to write.
REQ-009 msg_len  input  $clog2(MSG_DEPTH)+1  message length, 0..MSG_DEPTH, sampled on an accepted start.
REQ-010 start  input  1  start-scroll pulse.
REQ-011 stop  input  1  abort pulse.
REQ-012 pause  input  1  level; freezes scrolling while high.
REQ-013 hex3, hex2, hex1, hex0  output  4 each  digit codes to the display multiplexer; hex3 is leftmost.
REQ-014 dp_out  output  4  decimal points to the display multiplexer.
REQ-015 busy  output  1  high in SCROLL or PAUSED.
REQ-016 done  output  1  one-cycle pulse when a message has fully scrolled out.

Function
REQ-017 States SHALL be IDLE, SCROLL, PAUSED and DONE.
REQ-018 A write with wr_en=1 SHALL update buffer[wr_addr] at the clock edge in any state; a write during SCROLL is visible at the next step or earlier.
REQ-019 start SHALL be accepted only in IDLE or DONE with msg_len!=0. It SHALL latch len, clear pos to 0, clear the tick counter and enter SCROLL at the next edge; start with msg_len=0 SHALL be ignored.
REQ-020 msg_len>MSG_DEPTH SHALL be saturated to MSG_DEPTH at latch.
REQ-021 Window: digit k (hex0 is k=0) SHALL show buffer[pos-k] when 0<=pos-k<len, otherwise BLANK_CODE; outputs are combinational from registered pos, len and buffer, so pos 0 is visible the cycle after start.
REQ-022 In SCROLL the tick counter SHALL count 0..TICK_DIV-1. On the terminal count pos SHALL increment, so each step lasts exactly TICK_DIV cycles.
REQ-023 At the terminal count with pos=len+2, the block SHALL pulse done, enter DONE and hold pos (window shows only blanks except per REQ-030).
REQ-024 pause=1 in SCROLL SHALL enter PAUSED, freezing pos and the tick counter. pause=0 SHALL return to SCROLL and resume the count without restarting it.
REQ-025 stop in SCROLL or PAUSED SHALL return to IDLE next edge with no done pulse. stop SHALL win over simultaneous start or pause.
REQ-026 In IDLE all hex outputs SHALL be BLANK_CODE.
REQ-027 dp_out SHALL be 4'b0001 in PAUSED and 4'b0000 otherwise.
REQ-028 start in SCROLL or PAUSED SHALL be ignored.

Reset
REQ-029 Reset SHALL force IDLE, pos=0, len=0, tick=0, done=0, busy=0, hex*=BLANK_CODE and dp_out=0. Buffer contents are unspecified after reset; reset mid-scroll aborts immediately with no done pulse.

Configuration
REQ-030 With SCROLL_LOOP_EN defined, the terminal step of REQ-023 SHALL pulse done, wrap pos to 0 and stay in SCROLL until stop; without it, the behaviour is exactly REQ-023.

Structure
REQ-031 Package disp_pkg SHALL hold the state enum, the default BLANK_CODE and the DISP_DIGITS=4 constant.
REQ-032 The prescaler SHALL be a sub-module tick_gen with clear, enable and a terminal-count tick output.

Verification (TICK_DIV=4, MSG_DEPTH=16)
REQ-033 Write codes 0,1,2 at addr 0..2, then msg_len=3 with start. Required: pos 0 shows hex0=0 and others=F. Each 4 cycles the window steps: (1,0), (2,1,0), (F,2,1,0 on hex0..hex3), then (F,F,2,1) and (F,F,F,2). done pulses 4 cycles after the last window, 24 cycles after start, followed by DONE with busy=0.
REQ-034 Start with msg_len=0: state stays IDLE, busy=0, outputs all F.
REQ-035 Assert pause for 10 cycles mid-step 2. Required: dp_out=0001, pos frozen, and the step completes with the remaining tick count after release.
REQ-036 Assert stop and start in the same cycle during SCROLL: IDLE next cycle, no done pulse, all outputs F.
REQ-037 Assert reset mid-scroll: all outputs at reset values in the same cycle. With SCROLL_LOOP_EN, confirm pos wraps to 0 after done and scrolling continues.

Source files
------------

// File: rtl/disp_pkg.sv
// Shared types and constants for the message scroller.
package disp_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SCROLL = 2'd1,
        ST_PAUSED = 2'd2,
        ST_DONE   = 2'd3
    } disp_state_e;

    localparam int         DISP_DIGITS = 4;
    localparam logic [3:0] DISP_BLANK  = 4'hf;

endpackage

// File: rtl/tick_gen.sv
// Scroll-step prescaler: counts 0..TICK_DIV-1 while enabled, tick marks the terminal count.
module tick_gen #(
    parameter int TICK_DIV = 12_500_000
) (
    input  logic clk,
    input  logic reset,
    input  logic clear,
    input  logic enable,
    output logic tick
);

    localparam int CW = $clog2(TICK_DIV);

    logic [CW-1:0] cnt;

    assign tick = enable && (cnt == CW'(TICK_DIV - 1));

    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            cnt <= '0;
        else if (clear)
            cnt <= '0;
        else if (enable)
            cnt <= tick ? '0 : cnt + 1'b1;
    end

endmodule

// File: rtl/disp_msg_scroller.sv
// Scrolls a message of 4-bit codes right-to-left across four display digits.
// Define SCROLL_LOOP_EN to restart the message after each pass instead of stopping.
module disp_msg_scroller
    import disp_pkg::*;
#(
    parameter int         MSG_DEPTH  = 16,
    parameter int         TICK_DIV   = 12_500_000,
    parameter logic [3:0] BLANK_CODE = DISP_BLANK
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         wr_en,
    input  logic [$clog2(MSG_DEPTH)-1:0] wr_addr,
    input  logic [3:0]                   wr_data,
    input  logic [$clog2(MSG_DEPTH):0]   msg_len,
    input  logic                         start,
    input  logic                         stop,
    input  logic                         pause,
    output logic [3:0]                   hex3,
    output logic [3:0]                   hex2,
    output logic [3:0]                   hex1,
    output logic [3:0]                   hex0,
    output logic [3:0]                   dp_out,
    output logic                         busy,
    output logic                         done
);

    localparam int AW = $clog2(MSG_DEPTH);
    localparam int LW = AW + 1;
    localparam int PW = AW + 2;   // pos runs up to len+2

    disp_state_e state, state_nxt;

    logic [3:0]    buffer [MSG_DEPTH];
    logic [LW-1:0] len;
    logic [PW-1:0] pos;
    logic          start_ok;
    logic          tick;
    logic          last_step;
    logic [DISP_DIGITS-1:0][3:0] digit;

    assign start_ok  = ((state == ST_IDLE) || (state == ST_DONE)) && start && (msg_len != '0);
    assign last_step = tick && (pos == PW'(len) + PW'(2));

    // stop masks the prescaler so an abort can never coincide with a done pulse
    tick_gen #(.TICK_DIV(TICK_DIV)) u_tick (
        .clk    (clk),
        .reset  (reset),
        .clear  (start_ok),
        .enable ((state == ST_SCROLL) && !stop),
        .tick   (tick)
    );

    always_ff @(posedge clk) begin
        if (wr_en)
            buffer[wr_addr] <= wr_data;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            state <= ST_IDLE;
        else
            state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        unique case (state)
            ST_IDLE, ST_DONE: if (start_ok) state_nxt = ST_SCROLL;
            ST_SCROLL: begin
                if (stop)
                    state_nxt = ST_IDLE;
                else if (last_step)
`ifdef SCROLL_LOOP_EN
                    state_nxt = ST_SCROLL;
`else
                    state_nxt = ST_DONE;
`endif
                else if (pause)
                    state_nxt = ST_PAUSED;
            end
            ST_PAUSED: begin
                if (stop)
                    state_nxt = ST_IDLE;
                else if (!pause)
                    state_nxt = ST_SCROLL;
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    always_comb begin
        busy   = (state == ST_SCROLL) || (state == ST_PAUSED);
        dp_out = (state == ST_PAUSED) ? 4'b0001 : 4'b0000;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pos  <= '0;
            len  <= '0;
            done <= 1'b0;
        end else begin
            done <= last_step;
            if (start_ok) begin
                pos <= '0;
                len <= (msg_len > LW'(MSG_DEPTH)) ? LW'(MSG_DEPTH) : msg_len;
            end else if (last_step) begin
`ifdef SCROLL_LOOP_EN
                pos <= '0;
`endif
            end else if (tick) begin
                pos <= pos + 1'b1;
            end
        end
    end

    // Outside SCROLL/PAUSED the window is forced blank, so DONE shows no tail
    for (genvar k = 0; k < DISP_DIGITS; k++) begin : g_digit
        logic [PW-1:0] rel;
        assign rel      = pos - PW'(k);
        assign digit[k] = (busy && (pos >= PW'(k)) && (rel < PW'(len)))
                          ? buffer[rel[AW-1:0]] : BLANK_CODE;
    end

    assign hex0 = digit[0];
    assign hex1 = digit[1];
    assign hex2 = digit[2];
    assign hex3 = digit[3];

endmodule

// File: tb/tb_disp_msg_scroller.sv
// Directed bench for disp_msg_scroller with TICK_DIV=4, MSG_DEPTH=16.
module tb_disp_msg_scroller;

    logic       clk = 1'b0;
    logic       reset;
    logic       wr_en;
    logic [3:0] wr_addr;
    logic [3:0] wr_data;
    logic [4:0] msg_len;
    logic       start, stop, pause;
    logic [3:0] hex3, hex2, hex1, hex0, dp_out;
    logic       busy, done;

    int n_vec = 0;
    int n_err = 0;

    disp_msg_scroller #(.MSG_DEPTH(16), .TICK_DIV(4), .BLANK_CODE(4'hf)) dut (
        .clk(clk), .reset(reset), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
        .msg_len(msg_len), .start(start), .stop(stop), .pause(pause),
        .hex3(hex3), .hex2(hex2), .hex1(hex1), .hex0(hex0),
        .dp_out(dp_out), .busy(busy), .done(done)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %h, want %h", tag, obs, exp);
        end
    endtask

    task automatic cyc(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    function automatic logic [15:0] win();
        return {hex3, hex2, hex1, hex0};
    endfunction

    // windows for the message 0,1,2 at pos 0..5, packed hex3..hex0
    logic [15:0] exp_win [6] = '{16'hFFF0, 16'hFF01, 16'hF012, 16'h012F, 16'h12FF, 16'h2FFF};

    initial begin
        logic seen;
        reset = 1'b1; wr_en = 0; wr_addr = 0; wr_data = 0;
        msg_len = 0; start = 0; stop = 0; pause = 0;
        cyc(2);
        chk("rst_win", win(), 16'hFFFF);
        chk("rst_busy", {15'd0, busy}, 16'd0);
        chk("rst_done", {15'd0, done}, 16'd0);
        chk("rst_dp", {12'd0, dp_out}, 16'd0);
        reset = 1'b0;
        cyc(1);

        // start with zero length is ignored
        msg_len = 5'd0; start = 1; cyc(1); start = 0;
        chk("len0_busy", {15'd0, busy}, 16'd0);
        chk("len0_win", win(), 16'hFFFF);
        cyc(3);
        chk("len0_idle", {15'd0, busy}, 16'd0);

        for (int i = 0; i < 3; i++) begin
            wr_en = 1; wr_addr = 4'(i); wr_data = 4'(i); cyc(1);
        end
        wr_en = 0;

        // basic scroll
        msg_len = 5'd3; start = 1; cyc(1); start = 0;
        chk("scr_busy", {15'd0, busy}, 16'd1);
        chk("scr_w0", win(), exp_win[0]);
        for (int s = 1; s < 6; s++) begin
            cyc(3);
            chk($sformatf("scr_hold%0d", s - 1), win(), exp_win[s-1]);
            cyc(1);
            chk($sformatf("scr_w%0d", s), win(), exp_win[s]);
        end
        cyc(3);
        chk("pre_done", {15'd0, done}, 16'd0);
        chk("pre_done_win", win(), 16'h2FFF);
        cyc(1);
        chk("done_pulse", {15'd0, done}, 16'd1);
`ifdef SCROLL_LOOP_EN
        chk("loop_busy", {15'd0, busy}, 16'd1);
        chk("loop_wrap", win(), exp_win[0]);
        cyc(4);
        chk("loop_w1", win(), exp_win[1]);
`else
        chk("done_busy", {15'd0, busy}, 16'd0);
        chk("done_win", win(), 16'hFFFF);
        cyc(1);
        chk("done_once", {15'd0, done}, 16'd0);
        chk("done_stay", {15'd0, busy}, 16'd0);
`endif
        stop = 1; cyc(1); stop = 0;

        // pause for 10 cycles inside step 2
        msg_len = 5'd3; start = 1; cyc(1); start = 0;
        cyc(8);
        chk("pz_pos2", win(), exp_win[2]);
        cyc(1);
        pause = 1; cyc(1);
        chk("pz_dp", {12'd0, dp_out}, 16'h0001);
        chk("pz_busy", {15'd0, busy}, 16'd1);
        cyc(9);
        chk("pz_frozen", win(), exp_win[2]);
        chk("pz_dp_hold", {12'd0, dp_out}, 16'h0001);
        pause = 0; cyc(2);
        chk("pz_resume_dp", {12'd0, dp_out}, 16'h0000);
        chk("pz_remain", win(), exp_win[2]);
        cyc(1);
        chk("pz_step", win(), exp_win[3]);

        // stop beats a simultaneous start
        cyc(1);
        stop = 1; start = 1; cyc(1); stop = 0; start = 0;
        chk("stop_busy", {15'd0, busy}, 16'd0);
        chk("stop_win", win(), 16'hFFFF);
        seen = done;
        for (int i = 0; i < 30; i++) begin
            cyc(1);
            if (done || busy) seen = 1'b1;
        end
        chk("stop_quiet", {15'd0, seen}, 16'd0);

        // asynchronous reset while paused mid-scroll
        msg_len = 5'd3; start = 1; cyc(1); start = 0;
        cyc(6);
        pause = 1; cyc(1);
        chk("ar_pre_dp", {12'd0, dp_out}, 16'h0001);
        #2 reset = 1'b1;
        #1;
        chk("ar_win", win(), 16'hFFFF);
        chk("ar_busy", {15'd0, busy}, 16'd0);
        chk("ar_dp", {12'd0, dp_out}, 16'd0);
        chk("ar_done", {15'd0, done}, 16'd0);
        pause = 0;
        cyc(1);
        reset = 1'b0;
        cyc(2);
        chk("ar_idle", {15'd0, busy}, 16'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
